// File: rtl/flopr.sv
// rtl/flopr.sv - N-bit rising-edge register with synchronous active-low reset
module flopr #(
    parameter int             N           = 64,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Reset is folded into the next-state mux so the flop itself stays a plain D-type.
    always_comb begin
        q_d = d;
        if (!reset) begin
            q_d = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_flopr.sv
// tb/tb_flopr.sv - self-checking bench for flopr at widths 64, 8 and 1
module tb_flopr;

    localparam logic [7:0] RV8 = 8'hC3;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] d64;
    logic [7:0]  d8;
    logic        d1;
    logic [63:0] q64;
    logic [7:0]  q8;
    logic        q1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flopr dut64 (
        .clk   (clk),
        .reset (reset),
        .d     (d64),
        .q     (q64)
    );

    flopr #(.N(8), .RESET_VALUE(RV8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8)
    );

    flopr #(.N(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a register either loads its reset constant or the value present at the edge.
    task automatic cycle(input string tag, input logic r, input logic [63:0] v64,
                         input logic [7:0] v8, input logic v1);
        logic [63:0] e64;
        logic [7:0]  e8;
        logic        e1;
        @(negedge clk);
        reset = r;
        d64   = v64;
        d8    = v8;
        d1    = v1;
        e64   = r ? v64 : 64'd0;
        e8    = r ? v8  : RV8;
        e1    = r ? v1  : 1'b0;
        @(posedge clk);
        #1;
        check({tag, "/q64"}, q64, e64);
        check({tag, "/q8"},  {56'd0, q8}, {56'd0, e8});
        check({tag, "/q1"},  {63'd0, q1}, {63'd0, e1});
    endtask

    initial begin
        reset = 1'b1;
        d64   = '0;
        d8    = '0;
        d1    = 1'b0;

        cycle("reset", 1'b0, 64'h5, 8'h5A, 1'b1);

        for (int i = 0; i < 20; i++) begin
            cycle("seq", 1'b1, 64'(i % 10), 8'(i % 10), 1'(i % 2));
        end

        cycle("hold_pre", 1'b1, 64'd3, 8'd3, 1'b1);
        @(negedge clk);
        d64 = 64'd7;
        #2;
        check("hold_d7", q64, 64'd3);
        d64 = 64'd9;
        #1;
        check("hold_d9", q64, 64'd3);
        @(posedge clk);
        #1;
        check("hold_edge", q64, 64'd9);

        cycle("mid_pre", 1'b1, 64'd6, 8'd6, 1'b0);
        cycle("mid_rst", 1'b0, 64'd8, 8'd8, 1'b1);
        cycle("mid_rel", 1'b1, 64'd2, 8'd2, 1'b1);

        cycle("sync_pre", 1'b1, 64'd4, 8'd4, 1'b1);
        #2;
        reset = 1'b0;
        #2;
        check("sync_low", q64, 64'd4);
        check("sync_low8", {56'd0, q8}, 64'd4);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("sync_after", q64, 64'd4);

        cycle("full_ones", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        cycle("full_pat",  1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 8'hA5, 1'b0);
        cycle("full_rst",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);

        for (int i = 0; i < 60; i++) begin
            cycle("rand", ($urandom_range(0, 9) != 0),
                  {$urandom, $urandom}, 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
